// File: rtl/token_link_arbiter.sv
// ---------------------------------------------------------------------------
// token_link_arbiter
//   Shares one downstream Valid/Nack token link between NUM_REQ requesters.
//   Round-robin grant held for a whole message (first beat to Last), an idle
//   timeout reclaims the link from a silent owner, and a one-cycle release
//   bubble follows every grant.
//
// Ports
//   clock        in   system clock
//   reset        in   asynchronous active-low reset
//   I_Req_Valid  in   [NUM_REQ]            valid token per requester
//   I_Req_Last   in   [NUM_REQ]            last beat flag, qualified by valid
//   I_Req_Data   in   [NUM_REQ*WIDTH_DATA] requester i at [i*WIDTH_DATA +: WIDTH_DATA]
//   O_Req_Nack   out  [NUM_REQ]            nack back to each requester
//   O_Valid      out                       valid to the shared link
//   O_Last       out                       last flag to the shared link
//   O_Data       out  [WIDTH_DATA]         data to the shared link
//   I_Nack       in                        nack from the shared link
//   O_Grant      out  [NUM_REQ]            registered one-hot grant
//   O_Busy       out                       arbiter not idle
// ---------------------------------------------------------------------------
module token_link_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH_DATA = 32,
    parameter int MAX_IDLE   = 15
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            I_Req_Valid,
    input  logic [NUM_REQ-1:0]            I_Req_Last,
    input  logic [NUM_REQ*WIDTH_DATA-1:0] I_Req_Data,
    output logic [NUM_REQ-1:0]            O_Req_Nack,
    output logic                          O_Valid,
    output logic                          O_Last,
    output logic [WIDTH_DATA-1:0]         O_Data,
    input  logic                          I_Nack,
    output logic [NUM_REQ-1:0]            O_Grant,
    output logic                          O_Busy
);

    localparam int PW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [PW-1:0]     gidx_r, gidx_s;
    logic [PW-1:0]     ptr_r, ptr_s;
    logic [7:0]        cnt_r, cnt_s;
    logic [NUM_REQ-1:0] grant_r, grant_s;
    logic              busy_r;

    logic [PW-1:0]     sel_idx_s;
    logic              sel_found_s;
    logic [PW-1:0]     cand_s;
    logic              valid_g_s;
    logic              last_g_s;
    logic [7:0]        cnt_inc_s;

    // Modulo-NUM_REQ increment by explicit compare, so non-power-of-two counts wrap correctly.
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
        if (v == PW'(NUM_REQ - 1)) begin
            return {PW{1'b0}};
        end else begin
            return v + PW'(1);
        end
    endfunction

    // Round-robin search: first valid requester at or after the pointer.
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = {PW{1'b0}};
        cand_s      = ptr_r;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!sel_found_s && I_Req_Valid[cand_s]) begin
                sel_found_s = 1'b1;
                sel_idx_s   = cand_s;
            end else begin
                sel_found_s = sel_found_s;
            end
            cand_s = wrap_inc(cand_s);
        end
    end

    assign valid_g_s = I_Req_Valid[gidx_r];
    assign last_g_s  = I_Req_Last[gidx_r] & valid_g_s;
    assign cnt_inc_s = (cnt_r == 8'hFF) ? cnt_r : cnt_r + 8'd1;

    // Next-state logic for FSM, grant, pointer and idle counter.
    always_comb begin
        state_s = state_r;
        gidx_s  = gidx_r;
        ptr_s   = ptr_r;
        cnt_s   = cnt_r;
        grant_s = grant_r;
        case (state_r)
            S_IDLE: begin
                if (sel_found_s) begin
                    state_s = S_GRANT;
                    gidx_s  = sel_idx_s;
                    grant_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_idx_s;
                    cnt_s   = 8'd0;
                end else begin
                    grant_s = {NUM_REQ{1'b0}};
                end
            end
            S_GRANT: begin
                if (valid_g_s) begin
                    // Any beat, stalled or not, proves the owner is alive.
                    cnt_s = 8'd0;
                    if (last_g_s && !I_Nack) begin
                        state_s = S_RELEASE;
                        ptr_s   = wrap_inc(gidx_r);
                        grant_s = {NUM_REQ{1'b0}};
                    end else begin
                        state_s = S_GRANT;
                    end
                end else begin
                    cnt_s = cnt_inc_s;
                    if (cnt_inc_s >= 8'(MAX_IDLE)) begin
                        state_s = S_RELEASE;
                        ptr_s   = wrap_inc(gidx_r);
                        grant_s = {NUM_REQ{1'b0}};
                        cnt_s   = 8'd0;
                    end else begin
                        state_s = S_GRANT;
                    end
                end
            end
            S_RELEASE: begin
                state_s = S_IDLE;
                grant_s = {NUM_REQ{1'b0}};
            end
            default: begin
                state_s = S_IDLE;
                grant_s = {NUM_REQ{1'b0}};
                cnt_s   = 8'd0;
            end
        endcase
    end

    // State registers; reset drops any grant immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
            gidx_r  <= {PW{1'b0}};
            ptr_r   <= {PW{1'b0}};
            cnt_r   <= 8'd0;
            grant_r <= {NUM_REQ{1'b0}};
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            gidx_r  <= gidx_s;
            ptr_r   <= ptr_s;
            cnt_r   <= cnt_s;
            grant_r <= grant_s;
            busy_r  <= (state_s != S_IDLE);
        end
    end

    // Link pass-through for the owner; everyone else valid sees a busy link.
    always_comb begin
        O_Valid    = 1'b0;
        O_Last     = 1'b0;
        O_Data     = {WIDTH_DATA{1'b0}};
        O_Req_Nack = I_Req_Valid;
        if (state_r == S_GRANT) begin
            O_Valid            = valid_g_s;
            O_Last             = last_g_s;
            O_Data             = I_Req_Data[gidx_r*WIDTH_DATA +: WIDTH_DATA];
            O_Req_Nack[gidx_r] = I_Nack;
        end else begin
            O_Valid = 1'b0;
        end
    end

    assign O_Grant = grant_r;
    assign O_Busy  = busy_r;

endmodule

// File: doc/token_link_arbiter.md
Name: token_link_arbiter

Overview:
- Shares one downstream Valid/Nack token link between NUM_REQ upstream requesters. Typical downstream: a retiming token stage or an ALU input port.
- Grants are round-robin and held for a whole message, from the first beat to the beat flagged Last.
- Downstream Nack is routed to the granted requester only. Every valid requester that is not granted sees Nack, so it stalls as it would on a busy link.
- An idle-timeout counter reclaims the link from a granted requester that stops sending.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- WIDTH_DATA, 32, data bits per beat.
- MAX_IDLE, 15, consecutive idle cycles while granted before the grant is revoked (1..255).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- I_Req_Valid  in  NUM_REQ  valid token per requester.
- I_Req_Last  in  NUM_REQ  final beat of message, qualified by valid.
- I_Req_Data  in  NUM_REQ*WIDTH_DATA  data; requester i occupies bits [i*WIDTH_DATA +: WIDTH_DATA].
- O_Req_Nack  out  NUM_REQ  nack token back to each requester.
- O_Valid  out  1  valid token to the shared link.
- O_Last  out  1  last flag to the shared link.
- O_Data  out  WIDTH_DATA  data to the shared link.
- I_Nack  in  1  nack token from the shared link.
- O_Grant  out  NUM_REQ  registered one-hot grant; all zero when idle.
- O_Busy  out  1  FSM is not in iDLE.

Behaviour:
- Reset: reset=0 asynchronously clears all state.
  - FSM=iDLE, O_Grant=0, round-robin pointer R_Ptr=0, idle counter R_Cnt=0, O_Busy=0.
  - While in iDLE, O_Valid=0, O_Last=0, O_Data=0, O_Req_Nack=I_Req_Valid.
  - Reset asserted mid-message drops the grant immediately. No beat is replayed.
- Beat accepted: beat = O_Valid & ~I_Nack, following the token protocol.
- FSM states: iDLE, gRANT, rLEASE.
- iDLE:
  - If any I_Req_Valid is set, select the first requester at or after R_Ptr, scanning upward with wrap-around modulo NUM_REQ.
  - Next cycle: O_Grant=onehot(sel), FSM=gRANT, R_Cnt=0.
  - Arbitration latency is 1 cycle. No beat is forwarded in the arbitration cycle, and all valid requesters get Nack=1 during that cycle.
- gRANT, with g the granted index:
  - Data path is combinational pass-through: O_Valid=I_Req_Valid[g], O_Last=I_Req_Last[g] & I_Req_Valid[g], O_Data=I_Req_Data[g].
  - O_Req_Nack[g]=I_Nack. For every i≠g, O_Req_Nack[i]=I_Req_Valid[i].
  - An accepted beat with Last=1 goes to rLEASE and sets R_Ptr=(g+1) mod NUM_REQ.
  - I_Nack=1 holds the grant indefinitely and keeps R_Cnt at 0, because a stall does not count as idle.
  - Idle cycle (I_Req_Valid[g]=0): R_Cnt increments, saturating at 255. When R_Cnt reaches MAX_IDLE, go to rLEASE and set R_Ptr=(g+1) mod NUM_REQ.
  - Any valid beat, accepted or stalled, clears R_Cnt.
- rLEASE: one-cycle bubble. O_Grant is cleared, outputs are as in iDLE, then FSM=iDLE. This bubble lets the downstream token stage drain its revert window.
- Simultaneous events in gRANT:
  - Last beat and I_Nack together: the beat is not accepted and the grant is held.
  - Timeout and a valid beat in the same cycle: the beat wins and R_Cnt clears.
- Fairness: under continuous requests from all requesters, each receives the grant exactly once per NUM_REQ messages.
- Widths: R_Cnt is 8 bits. R_Ptr and g are $clog2(NUM_REQ) bits. Pointer wrap uses explicit compare against NUM_REQ-1, so non-power-of-two NUM_REQ is supported.
- O_Busy=1 in gRANT and rLEASE.

Test Plan:
1. Reset, then I_Req_Valid=4'b0101, one-beat messages (Last=1), I_Nack=0.
   - Required: grants alternate 0,2,0,2.
   - Each grant appears 1 cycle after iDLE; each message takes 3 cycles (arbitrate, beat, rLEASE).
   - O_Req_Nack[2]=1 while requester 0 is granted.
2. Requester 1 sends a 4-beat message; I_Nack=1 on beats 2–3 for 3 cycles.
   - Required: O_Req_Nack[1] follows I_Nack and the grant stays 4'b0010 throughout.
   - O_Data sequence is unchanged and exactly 4 beats are accepted.
3. Requester 3 granted, sends 1 beat without Last, then drops valid, MAX_IDLE=15.
   - Required: rLEASE entered on the 15th idle cycle, then R_Ptr=0.
   - A pending requester 0 is granted 2 cycles later.
4. Last beat coincident with I_Nack=1, then I_Nack=0 the next cycle.
   - Required: no release on the first cycle; release after the second cycle.
   - O_Last is seen accepted exactly once.
5. reset=0 pulse mid-message while requester 2 is granted.
   - Required: O_Grant=0, O_Valid=0 asynchronously.
   - After release, arbitration restarts from R_Ptr=0, so requester 0 is granted if valid.
6. NUM_REQ=3, all requesters continuously valid with one-beat messages.
   - Required: grant order 0,1,2,0,1,2 and the pointer wraps from 2 to 0.
